// File: rtl/shares2shbus_serializer_pkg.sv
// Shared beat arithmetic and FSM encoding for the shares-to-bus serializer.
package shares2shbus_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Ceiling log2, never narrower than one bit so a single-beat counter still exists.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int calc_beats(input int count, input int chunk);
    return count / chunk;
  endfunction

endpackage

// File: rtl/shares2shbus_serializer_if.sv
// Packed-sharing input and chunked bus output handshakes of the serializer.
interface shares2shbus_serializer_if #(
  parameter int d     = 2,
  parameter int count = 128,
  parameter int chunk = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [d*count-1:0]   in_shares;
  logic                 out_valid;
  logic                 out_ready;
  logic [d*chunk-1:0]   out_shbus;
  logic                 out_last;

  modport master (
    output in_valid, in_shares, out_ready,
    input  in_ready, out_valid, out_shbus, out_last
  );

  modport slave (
    input  in_valid, in_shares, out_ready,
    output in_ready, out_valid, out_shbus, out_last
  );
endinterface

// File: rtl/shares2shbus_serializer_shares2shbus.sv
// Packed-to-bus rewiring: bit i of share j lands at position d*i+j. Wires only.
module shares2shbus #(
  parameter int d     = 2,
  parameter int count = 128
) (
  input  logic [d*count-1:0] shares,
  output logic [d*count-1:0] shbus
);
  for (genvar i = 0; i < count; i++) begin : g_bit
    for (genvar j = 0; j < d; j++) begin : g_share
      assign shbus[d*i+j] = shares[count*j+i];
    end
  end
endmodule

// File: rtl/shares2shbus_serializer.sv
// Loads one packed sharing into per-share shift registers and streams it out
// chunk by chunk in bus representation.
//   state | meaning
//   IDLE  | share registers empty, waiting for a sharing
//   SEND  | presenting beat cnt_q on the output bus
module shares2shbus_serializer
  import shares2shbus_serializer_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 128,
  parameter int chunk = 32
) (
  input  logic                    clk,
  input  logic                    syn_rst,
  shares2shbus_serializer_if.slave bus
);
  localparam int BEATS = calc_beats(count, chunk);
  localparam int CW    = clog2_min1(BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if ((count % chunk) != 0) begin : g_bad_chunk
    $error("shares2shbus_serializer: count must be a multiple of chunk");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [count-1:0] share_q [d];
  logic [count-1:0] share_d [d];
  logic [d*chunk-1:0] low_slices;
  logic             load;
  logic             advance;

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      for (int j = 0; j < d; j++) share_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      for (int j = 0; j < d; j++) share_q[j] <= share_d[j];
    end
  end

  assign load    = bus.in_valid & bus.in_ready;
  assign advance = bus.out_valid & bus.out_ready;

  // A reload on the accepted last beat overrides the drain to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int j = 0; j < d; j++) share_d[j] = share_q[j];
    if (advance) begin
      for (int j = 0; j < d; j++) share_d[j] = share_q[j] >> chunk;
      cnt_d = cnt_q + 1'b1;
      if (last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
    if (load) begin
      for (int j = 0; j < d; j++) share_d[j] = bus.in_shares[count*j +: count];
      cnt_d   = '0;
      state_d = SEND;
    end
    last_d = (state_d == SEND) && (cnt_d == LAST_CNT);
  end

  always_comb begin
    bus.out_valid = (state_q == SEND);
    bus.out_last  = last_q;
    bus.in_ready  = (state_q == IDLE) || ((state_q == SEND) && last_q && bus.out_ready);
  end

  for (genvar j = 0; j < d; j++) begin : g_low
    assign low_slices[chunk*j +: chunk] = share_q[j][chunk-1:0];
  end

  shares2shbus #(
    .d     (d),
    .count (chunk)
  ) u_rewire (
    .shares (low_slices),
    .shbus  (bus.out_shbus)
  );

endmodule

// File: tb/tb_shares2shbus_serializer.sv
// Self-checking bench: directed vector table on a small instance, reset corner,
// then scoreboard runs on a single-beat and a four-beat instance.
module tb_shares2shbus_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst_a, rst_b, rst_c;

  shares2shbus_serializer_if #(.d(2), .count(8),   .chunk(4))   if_a ();
  shares2shbus_serializer_if #(.d(3), .count(128), .chunk(128)) if_b ();
  shares2shbus_serializer_if #(.d(2), .count(128), .chunk(32))  if_c ();

  shares2shbus_serializer #(.d(2), .count(8),   .chunk(4))   dut_a (.clk(clk), .syn_rst(rst_a), .bus(if_a));
  shares2shbus_serializer #(.d(3), .count(128), .chunk(128)) dut_b (.clk(clk), .syn_rst(rst_b), .bus(if_b));
  shares2shbus_serializer #(.d(2), .count(128), .chunk(32))  dut_c (.clk(clk), .syn_rst(rst_c), .bus(if_c));

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_bus;
    logic       e_last;
  } vec_t;

  typedef struct {
    logic [383:0] bus;
    logic         last;
  } beat_t;

  vec_t         vecs [15];
  logic [383:0] sb_b [$];
  beat_t        sb_c [$];
  beat_t        bt;
  logic [383:0] tmp;
  logic [383:0] prev_bus;
  logic         prev_last;
  logic         prev_stall;
  logic         hs;
  int           got_b, sent_c, recvd_c, cyc_c;

  localparam int NB = 30;
  localparam int NC = 40;
  localparam int C_LIMIT = 4000;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference rewiring straight from the bit-placement definition.
  function automatic logic [383:0] model_beat(input logic [383:0] sh, input int dd,
                                              input int cnt, input int chk, input int k);
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < chk; i++)
      for (int j = 0; j < dd; j++)
        r[dd*i+j] = sh[cnt*j + chk*k + i];
    return r;
  endfunction

  function automatic logic [383:0] rand_wide();
    logic [383:0] r;
    for (int w = 0; w < 12; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.in_valid = 1'b0; if_a.out_ready = 1'b0; if_a.in_shares = 16'h3CA5;
    if_b.in_valid = 1'b0; if_b.out_ready = 1'b0; if_b.in_shares = '0;
    if_c.in_valid = 1'b0; if_c.out_ready = 1'b0; if_c.in_shares = '0;

    //             iv  ordy ir  ov  bus    last
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h4E, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h4E, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h4E, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h4E, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Instance A: directed table (basic transfer, stall, back-to-back).
    for (int n = 0; n < 15; n++) begin
      if_a.in_valid  = vecs[n].iv;
      if_a.out_ready = vecs[n].ordy;
      @(negedge clk);
      check($sformatf("a vec%0d in_ready", n),  384'(if_a.in_ready),  384'(vecs[n].e_ir));
      check($sformatf("a vec%0d out_valid", n), 384'(if_a.out_valid), 384'(vecs[n].e_ov));
      check($sformatf("a vec%0d out_shbus", n), 384'(if_a.out_shbus), 384'(vecs[n].e_bus));
      check($sformatf("a vec%0d out_last", n),  384'(if_a.out_last),  384'(vecs[n].e_last));
      @(posedge clk);
      #1;
    end

    // Instance A: reset after beat0 is accepted.
    if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    @(negedge clk);
    check("a rst beat0", 384'(if_a.out_shbus), 384'(8'hB1));
    @(posedge clk); #1;
    if_a.out_ready = 1'b0;
    @(negedge clk);
    check("a rst beat1", 384'(if_a.out_shbus), 384'(8'h4E));
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("a post-rst out_valid", 384'(if_a.out_valid), 384'(1'b0));
    check("a post-rst out_shbus", 384'(if_a.out_shbus), 384'(8'h00));
    check("a post-rst in_ready",  384'(if_a.in_ready),  384'(1'b1));
    check("a post-rst out_last",  384'(if_a.out_last),  384'(1'b0));
    @(posedge clk); #1;
    if_a.in_valid = 1'b1;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    @(negedge clk);
    check("a restart out_valid", 384'(if_a.out_valid), 384'(1'b1));
    check("a restart out_shbus", 384'(if_a.out_shbus), 384'(8'hB1));
    check("a restart out_last",  384'(if_a.out_last),  384'(1'b0));
    @(posedge clk); #1;

    // Instance B: one beat per sharing, continuous traffic.
    got_b = 0;
    if_b.out_ready = 1'b1;
    for (int cyc = 0; cyc < NB + 3; cyc++) begin
      if (cyc < NB) begin
        if_b.in_valid  = 1'b1;
        if_b.in_shares = rand_wide();
      end else begin
        if_b.in_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("b cyc%0d out_valid", cyc), 384'(if_b.out_valid),
            384'((cyc >= 1) && (cyc <= NB)));
      if (cyc < NB) check($sformatf("b cyc%0d in_ready", cyc), 384'(if_b.in_ready), 384'(1'b1));
      if (if_b.out_valid) begin
        check($sformatf("b cyc%0d out_last", cyc), 384'(if_b.out_last), 384'(1'b1));
        check($sformatf("b cyc%0d expected beat", cyc), 384'(sb_b.size() != 0), 384'(1'b1));
        if (sb_b.size() != 0) begin
          tmp = sb_b.pop_front();
          check($sformatf("b cyc%0d out_shbus", cyc), if_b.out_shbus, tmp);
        end
        got_b++;
      end
      if (if_b.in_valid && if_b.in_ready) sb_b.push_back(model_beat(if_b.in_shares, 3, 128, 128, 0));
      @(posedge clk);
      #1;
    end
    check("b beat count", 384'(got_b), 384'(NB));

    // Instance C: random stalls on both sides against the scoreboard.
    sent_c = 0; recvd_c = 0; cyc_c = 0; prev_stall = 1'b0;
    prev_bus = '0; prev_last = 1'b0;
    while ((sent_c < NC || sb_c.size() != 0) && cyc_c < C_LIMIT) begin
      if (!if_c.in_valid && sent_c < NC && $urandom_range(0, 2) != 0) begin
        tmp = rand_wide();
        tmp[383:256] = '0;
        if_c.in_valid  = 1'b1;
        if_c.in_shares = tmp[255:0];
      end
      if_c.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        check("c stall out_valid", 384'(if_c.out_valid), 384'(1'b1));
        check("c stall out_shbus", 384'(if_c.out_shbus), prev_bus);
        check("c stall out_last",  384'(if_c.out_last),  384'(prev_last));
      end
      if (if_c.out_valid && if_c.out_ready) begin
        check("c expected beat", 384'(sb_c.size() != 0), 384'(1'b1));
        if (sb_c.size() != 0) begin
          bt = sb_c.pop_front();
          check($sformatf("c beat%0d out_shbus", recvd_c), 384'(if_c.out_shbus), bt.bus);
          check($sformatf("c beat%0d out_last", recvd_c),  384'(if_c.out_last),  384'(bt.last));
        end
        recvd_c++;
      end
      hs = if_c.in_valid && if_c.in_ready;
      if (hs) begin
        tmp = '0;
        tmp[255:0] = if_c.in_shares;
        for (int k = 0; k < 4; k++) begin
          bt.bus  = model_beat(tmp, 2, 128, 32, k);
          bt.last = (k == 3);
          sb_c.push_back(bt);
        end
        sent_c++;
      end
      prev_stall = if_c.out_valid && !if_c.out_ready;
      prev_bus   = 384'(if_c.out_shbus);
      prev_last  = if_c.out_last;
      @(posedge clk);
      #1;
      if (hs) if_c.in_valid = 1'b0;
      cyc_c++;
    end
    check("c finished within cycle budget", 384'(cyc_c < C_LIMIT), 384'(1'b1));
    check("c sharings sent", 384'(sent_c), 384'(NC));
    check("c beats received", 384'(recvd_c), 384'(NC * 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
